// File: rtl/mips_div_pkg.sv
// Shared types and constants for the multi-cycle MIPS divider (div, div_step).
package mips_div_pkg;

   localparam int DIV_ITER  = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, trial-subtract, select.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem < divisor keeps |shifted - divisor| below 2^WIDTH, so diff[WIDTH] is a valid sign bit
   assign shifted = {rem, quo[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};

   always_comb begin
      quo_next = {quo[WIDTH-2:0], 1'b0};
      rem_next = shifted[WIDTH-1:0];
      if (!diff[WIDTH]) begin
         rem_next    = diff[WIDTH-1:0];
         quo_next[0] = 1'b1;
      end
   end

endmodule

// File: rtl/div.sv
// Multi-cycle DIV/DIVU unit returning {remainder, quotient}; one quotient bit per cycle.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes immediately.
module div
   import mips_div_pkg::*;
#(
   parameter int WIDTH = DIV_ITER
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               sign,
   input  logic               opn_valid,
   output logic               opn_ready,
   input  logic               cancel,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_t          state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [WIDTH-1:0]    rem_reg;
   logic [WIDTH-1:0]    quo_reg;
   logic [WIDTH-1:0]    div_reg;
   logic                neg_q_reg;
   logic                neg_r_reg;
   logic                res_valid_reg;
   logic                opn_ready_reg;
   logic [2*WIDTH-1:0]  result_reg;

   logic [WIDTH-1:0]    rem_next;
   logic [WIDTH-1:0]    quo_next;
   logic [WIDTH-1:0]    abs_a;
   logic [WIDTH-1:0]    abs_b;

   assign abs_a = (sign && a[WIDTH-1]) ? -a : a;
   assign abs_b = (sign && b[WIDTH-1]) ? -b : b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_reg),
      .quo      (quo_reg),
      .divisor  (div_reg),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         rem_reg       <= '0;
         quo_reg       <= '0;
         div_reg       <= '0;
         neg_q_reg     <= 1'b0;
         neg_r_reg     <= 1'b0;
         res_valid_reg <= 1'b0;
         opn_ready_reg <= 1'b1;
         result_reg    <= '0;
      end else if (cancel) begin
         // flush: drop whatever is in flight, but leave result as it was
         state_reg     <= IDLE;
         res_valid_reg <= 1'b0;
         opn_ready_reg <= 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (opn_valid) begin
                  rem_reg       <= '0;
                  quo_reg       <= abs_a;
                  div_reg       <= abs_b;
                  neg_q_reg     <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r_reg     <= sign & a[WIDTH-1];
                  cnt_reg       <= '0;
                  opn_ready_reg <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                  if (b == '0) begin
                     result_reg    <= {a, {WIDTH{1'b1}}};
                     res_valid_reg <= 1'b1;
                     state_reg     <= DONE;
                  end else begin
                     state_reg <= CALC;
                  end
`else
                  state_reg <= CALC;
`endif
               end
            end
            CALC: begin
               rem_reg <= rem_next;
               quo_reg <= quo_next;
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                  result_reg    <= {neg_r_reg ? -rem_next : rem_next,
                                    neg_q_reg ? -quo_next : quo_next};
                  res_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_reg <= 1'b0;
                  opn_ready_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg     <= IDLE;
               res_valid_reg <= 1'b0;
               opn_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign opn_ready = opn_ready_reg;
   assign res_valid = res_valid_reg;
   assign result    = result_reg;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: DIV/DIVU vectors, backpressure, cancel, reset, divide by zero.
module tb_div;
   import mips_div_pkg::*;

   localparam int W = 32;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = W + 1;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           sign;
   logic           opn_valid;
   logic           opn_ready;
   logic           cancel;
   logic           res_valid;
   logic           res_ready;
   logic [2*W-1:0] result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   div #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .sign      (sign),
      .opn_valid (opn_valid),
      .opn_ready (opn_ready),
      .cancel    (cancel),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .result    (result)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Presents the operation before edge E0, then scrambles the operands after E0.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
      @(negedge clk);
      a = av; b = bv; sign = sv; opn_valid = 1'b1;
      @(posedge clk);
      #1;
      opn_valid = 1'b0;
      a = $urandom; b = $urandom; sign = $urandom_range(0, 1);
   endtask

   // Returns k such that res_valid is first sampled high at edge E_k (0 = timeout).
   task automatic wait_result(output int lat);
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (res_valid) begin
            lat = k;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic accept();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      start_op(av, bv, sv);
      wait_result(lat);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, result, exp_res);
      $display("op %-10s a=%h b=%h sign=%0d -> result=%h lat=%0d", tag, av, bv, sv, result, lat);
      accept();
      check({tag, " released"}, {62'd0, res_valid, opn_ready}, 64'b01);
   endtask

   initial begin
      int lat;
      logic seen;
      logic [2*W-1:0] held;

      rst = 1'b1; a = '0; b = '0; sign = 1'b0;
      opn_valid = 1'b0; cancel = 1'b0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset res_valid", 64'(res_valid), 64'd0);
      check("reset result", result, 64'd0);
      check("reset opn_ready", 64'(opn_ready), 64'd1);
      rst = 1'b0;

      run_op("divu", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, W + 1);
      run_op("div_negA", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, W + 1);
      run_op("div_negB", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, W + 1);
      run_op("div_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, W + 1);
      run_op("divu_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, W + 1);
      run_op("div_zero", 32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, ZERO_LAT);

      // Backpressure: result must hold while opn_valid pulses are ignored
      start_op(32'd100, 32'd7, 1'b0);
      wait_result(lat);
      check("bp latency", 64'(lat), 64'(W + 1));
      held = result;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         opn_valid = i[0];
         a = 32'd9; b = 32'd3; sign = 1'b0;
         @(posedge clk);
         #1;
         check("bp res_valid", 64'(res_valid), 64'd1);
         check("bp result", result, held);
         check("bp opn_ready", 64'(opn_ready), 64'd0);
      end
      opn_valid = 1'b0;
      $display("op %-10s held result=%h for 5 cycles", "bp", held);
      accept();
      check("bp released", {62'd0, res_valid, opn_ready}, 64'b01);
      @(posedge clk);
      #1;
      check("bp idle", {62'd0, res_valid, opn_ready}, 64'b01);

      // cancel together with opn_valid in IDLE: not accepted
      @(negedge clk);
      a = 32'd9; b = 32'd3; opn_valid = 1'b1; cancel = 1'b1;
      @(posedge clk);
      #1;
      opn_valid = 1'b0; cancel = 1'b0;
      check("cancel_idle opn_ready", 64'(opn_ready), 64'd1);
      $display("op %-10s start with cancel rejected", "cancel0");

      // Cancel at E10 of a 100/7 operation
      start_op(32'd100, 32'd7, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      check("cancel opn_ready", 64'(opn_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen = seen | res_valid;
      end
      check("cancel no result", 64'(seen), 64'd0);
      $display("op %-10s cancelled at E10", "cancel");
      run_op("after_cxl", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, W + 1);

      // Reset at E15 mid-operation
      start_op(32'd100, 32'd7, 1'b0);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst res_valid", 64'(res_valid), 64'd0);
      check("midrst result", result, 64'd0);
      check("midrst opn_ready", 64'(opn_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen = seen | res_valid;
      end
      check("midrst no result", 64'(seen), 64'd0);
      $display("op %-10s reset at E15", "midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
